// File: rtl/dff_chk_pkg.sv
// Shared types for the D flip-flop response checker:
// FSM encoding, warm-up counter width and the reference Q model.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } chk_state_e;

    localparam int unsigned WARM_W = 8;

    // Q the flip-flop must present one edge after sampling d/rst.
    function automatic logic exp_next(input logic dut_rst, input logic d);
        return dut_rst ? 1'b0 : d;
    endfunction

endpackage

// File: rtl/dff_response_checker_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == {W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a D flip-flop: predicts Q one edge ahead,
// compares against the observed Q and flags/counts mismatches.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WARMUP      = 1,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             clear,
    input  logic             d_in,
    input  logic             dut_rst,
    input  logic             q_obs,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic             checking
);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

    chk_state_e        state_q;
    chk_state_e        state_d;
    logic [WARM_W-1:0] warm_q;
    logic [WARM_W-1:0] warm_d;

    logic exp_bit_q;
    logic exp_bit_d;
    logic exp_vld_q;
    logic exp_vld_d;
    logic mismatch_q;
    logic mismatch_d;
    logic err_q;
    logic err_d;

    logic in_check;
    logic cmp_en;
    logic cmp_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // Dropping chk_en or clearing always wins over any other transition.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (!chk_en || clear) begin
            state_d = ST_IDLE;
            warm_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WARM;
                    warm_d  = '0;
                end
                ST_WARM: begin
                    if (warm_q == WARM_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        warm_d = warm_q + WARM_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (cmp_bad && STOP_ON_ERR) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_check = (state_q == ST_CHECK);
        cmp_en   = in_check && exp_vld_q && chk_en && !clear;
        cmp_bad  = cmp_en && (q_obs != exp_bit_q);
    end

    always_comb begin
        exp_bit_d = exp_bit_q;
        exp_vld_d = exp_vld_q;
        if (state_d == ST_IDLE) begin
            exp_vld_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
            exp_bit_d = exp_next(dut_rst, d_in);
            exp_vld_d = 1'b1;
        end
    end

    always_comb begin
        mismatch_d = cmp_bad;
        err_d      = clear ? 1'b0 : (err_q || cmp_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_bit_q  <= 1'b0;
            exp_vld_q  <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            exp_bit_q  <= exp_bit_d;
            exp_vld_q  <= exp_vld_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_check_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(clear),
        .en_i (cmp_en),
        .cnt_o(check_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_mismatch_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(clear),
        .en_i (cmp_bad),
        .cnt_o(mismatch_cnt)
    );

    assign mismatch   = mismatch_q;
    assign err_sticky = err_q;
    assign checking   = in_check;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: three parameterisations share one
// stimulus stream; expectations are queued and checked by a monitor.
module tb_dff_response_checker;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic chk_en    = 1'b0;
    logic clear     = 1'b0;
    logic d_in      = 1'b0;
    logic dut_rst   = 1'b0;
    logic force_err = 1'b0;
    logic stuck     = 1'b0;
    logic dff_q     = 1'b0;
    logic q_obs;

    logic        a_mis, a_err, a_chk;
    logic [15:0] a_mcnt, a_ccnt;
    logic        b_mis, b_err, b_chk;
    logic [15:0] b_mcnt, b_ccnt;
    logic        c_mis, c_err, c_chk;
    logic [2:0]  c_mcnt, c_ccnt;

    int edge_n   = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int    tag;
        int    inst;
        string nm;
        int    mis;
        int    err;
        int    mcnt;
        int    ccnt;
        int    chk;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Stand-in for the flip-flop under test.
    always @(posedge clk) dff_q <= dut_rst ? 1'b0 : d_in;

    assign q_obs = stuck ? 1'b1 : (dff_q ^ force_err);

    dff_response_checker #(
        .CNT_W(16), .WARMUP(1), .STOP_ON_ERR(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clear(clear),
        .d_in(d_in), .dut_rst(dut_rst), .q_obs(q_obs),
        .mismatch(a_mis), .err_sticky(a_err),
        .mismatch_cnt(a_mcnt), .check_cnt(a_ccnt), .checking(a_chk)
    );

    dff_response_checker #(
        .CNT_W(16), .WARMUP(3), .STOP_ON_ERR(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clear(clear),
        .d_in(d_in), .dut_rst(dut_rst), .q_obs(q_obs),
        .mismatch(b_mis), .err_sticky(b_err),
        .mismatch_cnt(b_mcnt), .check_cnt(b_ccnt), .checking(b_chk)
    );

    dff_response_checker #(
        .CNT_W(3), .WARMUP(1), .STOP_ON_ERR(1'b0)
    ) u_c (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clear(clear),
        .d_in(d_in), .dut_rst(dut_rst), .q_obs(q_obs),
        .mismatch(c_mis), .err_sticky(c_err),
        .mismatch_cnt(c_mcnt), .check_cnt(c_ccnt), .checking(c_chk)
    );

    task automatic expect_at(input int tag, input int inst, input string nm,
                             input int mis, input int err, input int mcnt,
                             input int ccnt, input int chk);
        exp_t r;
        r.tag  = tag;
        r.inst = inst;
        r.nm   = nm;
        r.mis  = mis;
        r.err  = err;
        r.mcnt = mcnt;
        r.ccnt = ccnt;
        r.chk  = chk;
        sb.push_back(r);
    endtask

    task automatic expect_next(input int inst, input string nm, input int mis,
                               input int err, input int mcnt, input int ccnt,
                               input int chk);
        expect_at(edge_n + 1, inst, nm, mis, err, mcnt, ccnt, chk);
    endtask

    task automatic expect_zero_all(input int tag, input string nm);
        for (int k = 0; k < 3; k++) expect_at(tag, k, nm, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input logic en, input logic clr, input logic d,
                        input logic dr, input logic fe, input logic st);
        @(negedge clk);
        chk_en    = en;
        clear     = clr;
        d_in      = d;
        dut_rst   = dr;
        force_err = fe;
        stuck     = st;
    endtask

    task automatic cmp(input string nm, input string fld, input int act,
                       input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d expected %0d (edge %0d)",
                     nm, fld, act, exp, edge_n);
        end
    endtask

    exp_t mon_r;
    int   o_mis, o_err, o_mcnt, o_ccnt, o_chk;

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].tag <= edge_n) begin
            mon_r = sb.pop_front();
            if (mon_r.tag != edge_n) cmp(mon_r.nm, "edge", edge_n, mon_r.tag);
            case (mon_r.inst)
                0: begin
                    o_mis = int'(a_mis); o_err = int'(a_err);
                    o_mcnt = int'(a_mcnt); o_ccnt = int'(a_ccnt);
                    o_chk = int'(a_chk);
                end
                1: begin
                    o_mis = int'(b_mis); o_err = int'(b_err);
                    o_mcnt = int'(b_mcnt); o_ccnt = int'(b_ccnt);
                    o_chk = int'(b_chk);
                end
                default: begin
                    o_mis = int'(c_mis); o_err = int'(c_err);
                    o_mcnt = int'(c_mcnt); o_ccnt = int'(c_ccnt);
                    o_chk = int'(c_chk);
                end
            endcase
            cmp(mon_r.nm, "mismatch", o_mis, mon_r.mis);
            cmp(mon_r.nm, "err_sticky", o_err, mon_r.err);
            cmp(mon_r.nm, "mismatch_cnt", o_mcnt, mon_r.mcnt);
            cmp(mon_r.nm, "check_cnt", o_ccnt, mon_r.ccnt);
            cmp(mon_r.nm, "checking", o_chk, mon_r.chk);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [4:0] pat;
        int         na;
        int         nb;
        pat = 5'b10110;

        // Power-on reset, then release with chk_en low.
        step(0, 0, 0, 0, 0, 0);
        expect_zero_all(edge_n + 1, "rst_hold");
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        expect_zero_all(edge_n + 1, "rst_rel");

        // Correct flip-flop, D = 0,1,1,0,1 repeating over 20 edges.
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, pat[(i - 1) % 5], 0, 0, 0);
            na = (i > 2) ? i - 2 : 0;
            nb = (i > 4) ? i - 4 : 0;
            expect_next(0, "clean_a", 0, 0, 0, na, int'(i >= 2));
            expect_next(1, "clean_b", 0, 0, 0, nb, int'(i >= 4));
            expect_next(2, "clean_c", 0, 0, 0, (na > 7) ? 7 : na,
                        int'(i >= 2));
        end

        // Single forced error; B halts and freezes.
        step(1, 0, 0, 0, 1, 0);
        expect_next(0, "inj_a", 1, 1, 1, 19, 1);
        expect_next(1, "inj_b", 1, 1, 1, 17, 0);
        expect_next(2, "inj_c", 1, 1, 1, 7, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 0, 0, 0);
            expect_next(0, "post_a", 0, 1, 1, 20 + k, 1);
            expect_next(1, "halt_b", 0, 1, 1, 17, 0);
            expect_next(2, "post_c", 0, 1, 1, 7, 1);
        end

        // Clear together with a would-be mismatch: clear wins everywhere.
        step(1, 1, 0, 0, 1, 0);
        expect_zero_all(edge_n + 1, "clr_err");

        // Re-enable and force 10 consecutive mismatches.
        for (int j = 1; j <= 12; j++) begin
            step(1, 0, 0, 0, logic'(j >= 3), 0);
            na = (j > 2) ? j - 2 : 0;
            expect_next(0, "burst_a", int'(j >= 3), int'(j >= 3), na, na,
                        int'(j >= 2));
            expect_next(2, "burst_c", int'(j >= 3), int'(j >= 3),
                        (na > 7) ? 7 : na, (na > 7) ? 7 : na, int'(j >= 2));
            if (j < 5)
                expect_next(1, "burst_b", 0, 0, 0, 0, int'(j == 4));
            else
                expect_next(1, "burst_b", int'(j == 5), 1, 1, 1, 0);
        end

        // chk_en drops on a mismatching compare: dropped, counts hold.
        step(0, 0, 0, 0, 1, 0);
        expect_next(0, "drop_a", 0, 1, 10, 10, 0);
        expect_next(1, "drop_b", 0, 1, 1, 1, 0);
        expect_next(2, "drop_c", 0, 1, 7, 7, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_next(0, "idle_a", 0, 1, 10, 10, 0);

        // dut_rst with D=1 while Q is stuck at 1.
        step(0, 1, 0, 0, 0, 0);
        expect_next(0, "clr2_a", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_next(0, "dr_e1", 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        expect_next(0, "dr_e2", 0, 0, 0, 0, 1);
        step(1, 0, 1, 1, 0, 1);
        expect_next(0, "dr_e3", 0, 0, 0, 1, 1);
        step(1, 0, 1, 1, 0, 1);
        expect_next(0, "dr_e4", 1, 1, 1, 2, 1);
        step(1, 0, 1, 1, 0, 1);
        expect_next(0, "dr_e5", 1, 1, 2, 3, 1);
        step(1, 0, 0, 0, 0, 1);
        expect_next(0, "dr_e6", 1, 1, 3, 4, 1);
        step(1, 1, 0, 0, 0, 1);
        expect_next(0, "dr_clr", 0, 0, 0, 0, 0);

        // Async reset mid-run with nonzero counters.
        step(1, 0, 0, 0, 0, 0);
        expect_next(0, "pre_e1", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_next(0, "pre_e2", 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0);
        expect_next(0, "pre_e3", 1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        expect_next(0, "pre_e4", 0, 1, 1, 2, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_zero_all(edge_n, "async_rst");
        step(1, 0, 0, 0, 0, 0);
        expect_zero_all(edge_n + 1, "rst_held");
        step(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        expect_next(0, "rel_e1", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expect_next(0, "rel_e2", 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        expect_next(0, "rel_e3", 0, 0, 0, 1, 1);

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        cmp("scoreboard", "pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
